// File: rtl/cpu_run_monitor.sv
// Run monitor for a small pipelined CPU: counts cycles, taken branches and
// decode stalls during a run, detects program end or timeout, then drains.
module cpu_run_monitor #(
    parameter int              XLEN           = 32,
    parameter int              PC_BITS        = 5,
    parameter int              END_PC         = 22,
    parameter logic [XLEN-1:0] NOP_INST       = {XLEN{1'b0}},
    parameter int              DRAIN_CYCLES   = 5,
    parameter int              TIMEOUT_CYCLES = 2000,
    parameter int              CNT_BITS       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [PC_BITS-1:0]  f_pc,
    input  logic [XLEN-1:0]     f_inst,
    input  logic                ex_taken,
    input  logic                stall_d,
    output logic [2:0]          state,
    output logic                done,
    output logic                timeout,
    output logic [CNT_BITS-1:0] cycle_cnt,
    output logic [CNT_BITS-1:0] taken_cnt,
    output logic [CNT_BITS-1:0] stall_cnt,
    output logic [PC_BITS-1:0]  end_pc
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_DRAIN   = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    // A limit the saturating counter can never exceed disables the timeout.
    localparam bit TO_REACH = (TIMEOUT_CYCLES < ((1 << CNT_BITS) - 1));
    localparam logic [CNT_BITS-1:0] TO_LIM = CNT_BITS'(TIMEOUT_CYCLES);
    localparam logic [PC_BITS-1:0]  END_PC_V = PC_BITS'(END_PC);

    state_t              state_q, state_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;
    logic [CNT_BITS-1:0] cycle_q, cycle_d;
    logic [CNT_BITS-1:0] taken_q, taken_d;
    logic [CNT_BITS-1:0] stall_q, stall_d_nxt;
    logic [PC_BITS-1:0]  end_pc_q, end_pc_d;
    logic [DW-1:0]       drain_q, drain_d;

    logic                end_hit;
    logic                to_hit;
    logic [CNT_BITS-1:0] run_cyc;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d     = state_q;
        cycle_d     = cycle_q;
        taken_d     = taken_q;
        stall_d_nxt = stall_q;
        end_pc_d    = end_pc_q;
        drain_d     = drain_q;

        end_hit = (f_pc >= END_PC_V) && (f_inst == NOP_INST);
        run_cyc = sat_inc(cycle_q);
        to_hit  = TO_REACH && (run_cyc > TO_LIM);

        case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start) begin
                    state_d     = S_RUN;
                    cycle_d     = '0;
                    taken_d     = '0;
                    stall_d_nxt = '0;
                    end_pc_d    = '0;
                    drain_d     = '0;
                end
            end
            S_RUN: begin
                cycle_d = run_cyc;
                if (ex_taken) taken_d = sat_inc(taken_q);
                if (stall_d)  stall_d_nxt = sat_inc(stall_q);
                // End detection wins over a timeout landing on the same cycle.
                if (end_hit) begin
                    end_pc_d = f_pc;
                    if (DRAIN_CYCLES == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end else if (to_hit) begin
                    state_d = S_TIMEOUT;
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) state_d = S_DONE;
                else               drain_d = drain_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        done_d    = (state_d == S_DONE);
        timeout_d = (state_d == S_TIMEOUT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cycle_q   <= '0;
            taken_q   <= '0;
            stall_q   <= '0;
            end_pc_q  <= '0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            cycle_q   <= cycle_d;
            taken_q   <= taken_d;
            stall_q   <= stall_d_nxt;
            end_pc_q  <= end_pc_d;
            drain_q   <= drain_d;
        end
    end

    assign state     = state_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign cycle_cnt = cycle_q;
    assign taken_cnt = taken_q;
    assign stall_cnt = stall_q;
    assign end_pc    = end_pc_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: three parameterisations share one stimulus stream
// and are compared every cycle against a run-level reference model.
module tb_cpu_run_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  f_pc;
    logic [31:0] f_inst;
    logic        ex_taken;
    logic        stall_d;

    logic [2:0]  a_state, b_state, c_state;
    logic        a_done, b_done, c_done;
    logic        a_to, b_to, c_to;
    logic [15:0] a_cyc, a_tk, a_stl, b_cyc, b_tk, b_stl;
    logic [3:0]  c_cyc, c_tk, c_stl;
    logic [4:0]  a_epc, b_epc, c_epc;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    cpu_run_monitor u_def (
        .clk(clk), .rst(rst), .start(start), .f_pc(f_pc), .f_inst(f_inst),
        .ex_taken(ex_taken), .stall_d(stall_d), .state(a_state), .done(a_done),
        .timeout(a_to), .cycle_cnt(a_cyc), .taken_cnt(a_tk), .stall_cnt(a_stl),
        .end_pc(a_epc));

    cpu_run_monitor #(.TIMEOUT_CYCLES(8)) u_to (
        .clk(clk), .rst(rst), .start(start), .f_pc(f_pc), .f_inst(f_inst),
        .ex_taken(ex_taken), .stall_d(stall_d), .state(b_state), .done(b_done),
        .timeout(b_to), .cycle_cnt(b_cyc), .taken_cnt(b_tk), .stall_cnt(b_stl),
        .end_pc(b_epc));

    cpu_run_monitor #(.CNT_BITS(4), .DRAIN_CYCLES(0)) u_sat (
        .clk(clk), .rst(rst), .start(start), .f_pc(f_pc), .f_inst(f_inst),
        .ex_taken(ex_taken), .stall_d(stall_d), .state(c_state), .done(c_done),
        .timeout(c_to), .cycle_cnt(c_cyc), .taken_cnt(c_tk), .stall_cnt(c_stl),
        .end_pc(c_epc));

    // Reference model: one entry per instance, phase 0..4 as in the state output.
    int m_st[3], m_cyc[3], m_tk[3], m_stl[3], m_epc[3], m_left[3];
    int p_to[3]  = '{2000, 8, 2000};
    int p_max[3] = '{65535, 65535, 15};
    int p_dc[3]  = '{5, 5, 0};

    function automatic int bump(int v, int lim);
        return (v < lim) ? v + 1 : lim;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i] = 0; m_cyc[i] = 0; m_tk[i] = 0; m_stl[i] = 0; m_epc[i] = 0; m_left[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                m_st[i] = 0; m_cyc[i] = 0; m_tk[i] = 0; m_stl[i] = 0; m_epc[i] = 0;
            end else if (m_st[i] == 1) begin
                m_cyc[i] = bump(m_cyc[i], p_max[i]);
                if (ex_taken) m_tk[i] = bump(m_tk[i], p_max[i]);
                if (stall_d)  m_stl[i] = bump(m_stl[i], p_max[i]);
                if (f_pc >= 22 && f_inst == 0) begin
                    m_epc[i] = f_pc;
                    m_left[i] = p_dc[i];
                    m_st[i] = (p_dc[i] == 0) ? 3 : 2;
                end else if (m_cyc[i] > p_to[i]) begin
                    m_st[i] = 4;
                end
            end else if (m_st[i] == 2) begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) m_st[i] = 3;
            end else if (start) begin
                m_st[i] = 1; m_cyc[i] = 0; m_tk[i] = 0; m_stl[i] = 0; m_epc[i] = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_inst(input string nm, input int i, input logic [2:0] st, input logic dn,
                            input logic to, input logic [15:0] cyc, input logic [15:0] tk,
                            input logic [15:0] stl, input logic [4:0] epc);
        chk({nm, ".state"},     32'(st),  32'(m_st[i]));
        chk({nm, ".done"},      32'(dn),  32'(m_st[i] == 3));
        chk({nm, ".timeout"},   32'(to),  32'(m_st[i] == 4));
        chk({nm, ".cycle_cnt"}, 32'(cyc), 32'(m_cyc[i]));
        chk({nm, ".taken_cnt"}, 32'(tk),  32'(m_tk[i]));
        chk({nm, ".stall_cnt"}, 32'(stl), 32'(m_stl[i]));
        chk({nm, ".end_pc"},    32'(epc), 32'(m_epc[i]));
    endtask

    task automatic check_all();
        chk_inst("def", 0, a_state, a_done, a_to, a_cyc, a_tk, a_stl, a_epc);
        chk_inst("to8", 1, b_state, b_done, b_to, b_cyc, b_tk, b_stl, b_epc);
        chk_inst("sat", 2, c_state, c_done, c_to, {12'd0, c_cyc}, {12'd0, c_tk},
                 {12'd0, c_stl}, c_epc);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] v;
        v = $urandom;
        if (v == 32'd0) v = 32'd1;
        return v;
    endfunction

    task automatic drive(input logic s, input logic [4:0] pc, input logic [31:0] inst,
                         input logic tk, input logic st);
        start = s; f_pc = pc; f_inst = inst; ex_taken = tk; stall_d = st;
    endtask

    task automatic busy(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 5'($urandom_range(0, 31)), rand_inst(), 1'($urandom), 1'($urandom));
            cycle();
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        model_reset();
        #1 check_all();
        cycle();
        cycle();
        rst = 1'b1;
        drive(1'b0, 5'd31, 32'd0, 1'b1, 1'b1);
        cycle();
        cycle();

        // Nominal program: 21 busy cycles then NOP at PC 22, then drain.
        drive(1'b1, 5'd3, rand_inst(), 1'b0, 1'b0);
        cycle();
        busy(21);
        drive(1'b0, 5'd22, 32'd0, 1'($urandom), 1'($urandom));
        cycle();
        chk("nominal.cycle_cnt", 32'(a_cyc), 32'd22);
        chk("nominal.end_pc", 32'(a_epc), 32'd22);
        for (int k = 0; k < 5; k++) begin
            chk("nominal.in_drain", 32'(a_state), 32'd2);
            drive(1'($urandom), 5'($urandom_range(0, 31)), 32'($urandom), 1'($urandom), 1'($urandom));
            cycle();
        end
        chk("nominal.done", 32'(a_done), 32'd1);

        // A NOP below END_PC does not end the run.
        drive(1'b1, 5'd10, 32'd0, 1'b0, 1'b0);
        cycle();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 5'd10, 32'd0, 1'b0, 1'b0);
            cycle();
        end
        chk("low_nop.state", 32'(a_state), 32'd1);
        chk("low_nop.cycle_cnt", 32'(a_cyc), 32'd6);
        busy(5);
        drive(1'b0, 5'd30, 32'd0, 1'b0, 1'b0);
        cycle();
        busy(6);

        // Branch / stall counting, with extra events in DRAIN that must be ignored.
        drive(1'b1, 5'd0, rand_inst(), 1'b0, 1'b0);
        cycle();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 5'($urandom_range(0, 21)), rand_inst(), 1'(k < 3), 1'(k >= 2));
            cycle();
        end
        drive(1'b0, 5'd25, 32'd0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 5'd1, rand_inst(), 1'b1, 1'b1);
        cycle();
        busy(5);
        chk("events.taken_cnt", 32'(a_tk), 32'd3);
        chk("events.stall_cnt", 32'(a_stl), 32'd4);
        chk("events.done", 32'(a_done), 32'd1);

        // Long run without NOP: TIMEOUT_CYCLES=8 instance times out and holds.
        drive(1'b1, 5'd0, rand_inst(), 1'b1, 1'b1);
        cycle();
        for (int k = 0; k < 30; k++) begin
            drive(1'b0, 5'($urandom_range(0, 31)), rand_inst(), 1'b1, 1'($urandom));
            cycle();
        end
        chk("timeout.flag", 32'(b_to), 32'd1);
        chk("timeout.cycle_cnt", 32'(b_cyc), 32'd9);
        chk("saturate.cycle_cnt", 32'(c_cyc), 32'd15);

        // End condition on RUN cycle 9 beats the timeout.
        drive(1'b1, 5'd0, rand_inst(), 1'b0, 1'b0);
        cycle();
        busy(8);
        drive(1'b0, 5'd23, 32'd0, 1'b0, 1'b0);
        cycle();
        chk("end_vs_to.state", 32'(b_state), 32'd2);
        busy(6);
        chk("end_vs_to.done", 32'(b_done), 32'd1);
        drive(1'b1, 5'd0, rand_inst(), 1'b0, 1'b0);
        cycle();
        chk("restart.cycle_cnt", 32'(b_cyc), 32'd0);
        chk("restart.end_pc", 32'(b_epc), 32'd0);

        // Asynchronous reset in the middle of DRAIN.
        busy(3);
        drive(1'b0, 5'd24, 32'd0, 1'b1, 1'b1);
        cycle();
        busy(2);
        #2 rst = 1'b0;
        #1 model_reset();
        check_all();
        chk("async_rst.state", 32'(a_state), 32'd0);
        drive(1'b1, 5'd0, rand_inst(), 1'b0, 1'b0);
        cycle();
        rst = 1'b1;
        cycle();
        drive(1'b0, 5'd1, rand_inst(), 1'b1, 1'b0);
        cycle();
        chk("fresh.cycle_cnt", 32'(a_cyc), 32'd1);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 15) == 0), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 5) == 0) ? 32'd0 : rand_inst(),
                  1'($urandom), 1'($urandom));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_monitor.md
CPU_RUN_MONITOR -- requirements
Module: cpu_run_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32, instruction width.
REQ-002 SHALL have parameter PC_BITS, default 5, fetch PC width.
REQ-003 SHALL have parameter END_PC, default 22, minimum PC at which a NOP ends the program.
REQ-004 SHALL have parameter NOP_INST, default 32'h00000000, end-of-program instruction encoding.
REQ-005 SHALL have parameter DRAIN_CYCLES, default 5, pipeline-drain cycles after end detection.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 2000, run-cycle limit.
REQ-007 SHALL have parameter CNT_BITS, default 16, width of every event counter.
REQ-008 clk  input  1  single clock; all state updates on rising edge.
REQ-009 rst  input  1  asynchronous, active-low reset.
REQ-010 start  input  1  begin a run (sampled in IDLE, DONE, TIMEOUT only).
REQ-011 f_pc  input  PC_BITS  fetch-stage PC.
REQ-012 f_inst  input  XLEN  fetch-stage instruction.
REQ-013 ex_taken  input  1  EX-stage branch taken this cycle.
REQ-014 stall_d  input  1  decode stall this cycle.
REQ-015 state  output  3  FSM state: IDLE=0, RUN=1, DRAIN=2, DONE=3, TIMEOUT=4.
REQ-016 done  output  1  program completed and drained.
REQ-017 timeout  output  1  run exceeded TIMEOUT_CYCLES.
REQ-018 cycle_cnt  output  CNT_BITS  RUN cycles counted.
REQ-019 taken_cnt  output  CNT_BITS  taken branches counted.
REQ-020 stall_cnt  output  CNT_BITS  decode stall cycles counted.
REQ-021 end_pc  output  PC_BITS  f_pc latched at end detection.

Function
REQ-022 All outputs SHALL be registered; done = (state==DONE), timeout = (state==TIMEOUT).
REQ-023 IDLE/DONE/TIMEOUT with start=1 SHALL go to RUN next cycle, clearing all counters and end_pc to 0.
REQ-024 start SHALL be ignored in RUN and DRAIN.
REQ-025 Each RUN cycle: cycle_cnt +1; taken_cnt +1 if ex_taken; stall_cnt +1 if stall_d; all counters saturate at all-ones.
REQ-026 End condition in RUN: f_pc >= END_PC (unsigned) and f_inst == NOP_INST; that cycle's counting still SHALL occur, end_pc SHALL latch f_pc, next state DRAIN (DONE directly if DRAIN_CYCLES=0).
REQ-027 Timeout in RUN: updated cycle_cnt > TIMEOUT_CYCLES and no end condition -> TIMEOUT next cycle.
REQ-028 End condition SHALL take priority over timeout in the same cycle.
REQ-029 DRAIN SHALL last exactly DRAIN_CYCLES cycles (internal down-counter loaded on entry), then DONE; counters frozen in DRAIN.
REQ-030 DONE and TIMEOUT SHALL hold all outputs stable until start or reset.
REQ-031 Counters and end_pc SHALL only change in RUN or on start-clear.
REQ-032 Unreachable state encodings SHALL return to IDLE next cycle.

Reset
REQ-033 rst=0 SHALL immediately (asynchronously) force state=IDLE, done=0, timeout=0, all counters=0, end_pc=0, drain counter=0.
REQ-034 Reset assertion mid-RUN or mid-DRAIN SHALL abort the run; after release the block SHALL wait in IDLE for start.
REQ-035 Reset release SHALL be synchronous-safe: first state change no earlier than the first rising clk after rst=1.

Verification
REQ-036 Defaults; start pulse, f_inst nonzero for 21 cycles then f_pc=22, f_inst=0 -> cycle_cnt=22, end_pc=22, state DRAIN 5 cycles, then done=1.
REQ-037 f_inst=0 with f_pc=10 during RUN -> no end; RUN continues, cycle_cnt keeps incrementing.
REQ-038 TIMEOUT_CYCLES=8, no NOP -> after 9 RUN cycles timeout=1, cycle_cnt=9; hold stable 20 cycles.
REQ-039 ex_taken high 3 cycles, stall_d high 4 cycles during RUN, 1 cycle also in DRAIN -> taken_cnt=3, stall_cnt=4.
REQ-040 rst=0 asynchronously mid-DRAIN -> outputs zero before next clk edge; start after release -> fresh run, counters from 0.
REQ-041 TIMEOUT_CYCLES=8, end condition on RUN cycle 9 -> DRAIN, not TIMEOUT; start in DONE -> RUN with counters cleared.
